// File: rtl/fp_pkg.sv
// fp_pkg: shared constants and types for the FP result queue.
//   QNAN / POS_INF   : canonical special encodings produced by the fix-up
//   FLAG_*           : bit positions inside the 5-bit flag vector
//                      {invalid, overflow, underflow, zero, inf}
//   DEFAULT_DEPTH    : default FIFO entry count
//   fp_entry_t       : one queued entry (flags + corrected result)
package fp_pkg;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;

    localparam int FLAG_W         = 5;
    localparam int FLAG_INVALID   = 4;
    localparam int FLAG_OVERFLOW  = 3;
    localparam int FLAG_UNDERFLOW = 2;
    localparam int FLAG_ZERO      = 1;
    localparam int FLAG_INF       = 0;

    localparam int DEFAULT_DEPTH = 4;

    typedef struct packed {
        logic [FLAG_W-1:0] flags;
        logic [31:0]       y;
    } fp_entry_t;

endpackage

// File: rtl/fp_special_fixup.sv
// fp_special_fixup: combinational special-case correction of a raw
// single-precision add/sub result.
//   a, b  : operands as presented to the add/sub core
//   op    : 0 = add, 1 = subtract
//   y     : raw core result
//   y_fix : corrected result
//   flags : {invalid, overflow, underflow, zero, inf}
// Operands with a zero exponent (zero or denormal) are flushed to signed zero.
module fp_special_fixup
    import fp_pkg::*;
(
    input  logic [31:0]       a,
    input  logic [31:0]       b,
    input  logic              op,
    input  logic [31:0]       y,
    output logic [31:0]       y_fix,
    output logic [FLAG_W-1:0] flags
);

    logic [31:0] bmod;
    logic        eff;
    logic [7:0]  exp_a, exp_b, exp_y, exp_max;
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

    // B as seen by an adder: subtract is folded into B's sign.
    assign bmod    = {b[31] ^ op, b[30:0]};
    assign eff     = a[31] ^ b[31] ^ op;
    assign exp_a   = a[30:23];
    assign exp_b   = b[30:23];
    assign exp_y   = y[30:23];
    assign exp_max = (exp_a > exp_b) ? exp_a : exp_b;

    assign a_nan  = (exp_a == 8'hFF) && (a[22:0] != 23'd0);
    assign b_nan  = (exp_b == 8'hFF) && (b[22:0] != 23'd0);
    assign a_inf  = (exp_a == 8'hFF) && (a[22:0] == 23'd0);
    assign b_inf  = (exp_b == 8'hFF) && (b[22:0] == 23'd0);
    assign a_zero = (exp_a == 8'h00);
    assign b_zero = (exp_b == 8'h00);

    always_comb begin
        y_fix = y;
        flags = '0;
        if (a_nan || b_nan) begin
            y_fix               = QNAN;
            flags[FLAG_INVALID] = 1'b1;
        end else if (a_inf || b_inf) begin
            if (a_inf && b_inf && eff) begin
                y_fix               = QNAN;
                flags[FLAG_INVALID] = 1'b1;
            end else begin
                y_fix           = {(a_inf ? a[31] : bmod[31]), POS_INF[30:0]};
                flags[FLAG_INF] = 1'b1;
            end
        end else if (a_zero || b_zero) begin
            if (a_zero && b_zero) begin
                // Only (-0) + (-0) keeps a negative sign.
                y_fix            = {a[31] & bmod[31], 31'd0};
                flags[FLAG_ZERO] = 1'b1;
            end else if (a_zero) begin
                y_fix = bmod;
            end else begin
                y_fix = a;
            end
        end else if (eff && (a[30:0] == b[30:0])) begin
            // Exact cancellation always yields +0.
            y_fix            = 32'd0;
            flags[FLAG_ZERO] = 1'b1;
        end else if (exp_y == 8'hFF) begin
            y_fix                = {y[31], POS_INF[30:0]};
            flags[FLAG_OVERFLOW] = 1'b1;
            flags[FLAG_INF]      = 1'b1;
        end else if (eff && ((exp_y > exp_max) || (exp_y == 8'h00))) begin
            // A subtraction can never grow the exponent; treat as underflow.
            y_fix                 = {y[31], 31'd0};
            flags[FLAG_UNDERFLOW] = 1'b1;
            flags[FLAG_ZERO]      = 1'b1;
        end
    end

endmodule

// File: rtl/fp_result_queue.sv
// fp_result_queue: corrects raw add/sub results and queues them in a FIFO.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : upstream handshake (ready = not full)
//   in_a, in_b, in_op   : operands and operation of the add/sub core
//   in_y                : raw core result
//   out_valid/out_ready : downstream handshake
//   out_y, out_flags    : corrected head result and its flags
//   sticky_flags        : OR of flags of all accepted entries
//   clr_sticky          : clears sticky_flags (a same-cycle push still lands)
//   count               : current occupancy
module fp_result_queue
    import fp_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_a,
    input  logic [31:0]              in_b,
    input  logic                     in_op,
    input  logic [31:0]              in_y,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_y,
    output logic [FLAG_W-1:0]        out_flags,
    output logic [FLAG_W-1:0]        sticky_flags,
    input  logic                     clr_sticky,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fp_entry_t         mem [DEPTH];
    fp_entry_t         in_entry;
    fp_entry_t         head;
    logic [PW-1:0]     wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]     count_reg;
    logic [FLAG_W-1:0] sticky_reg;
    logic              push, pop;

    fp_special_fixup u_fixup (
        .a     (in_a),
        .b     (in_b),
        .op    (in_op),
        .y     (in_y),
        .y_fix (in_entry.y),
        .flags (in_entry.flags)
    );

    assign in_ready  = (count_reg < CW'(DEPTH));
    assign out_valid = (count_reg != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Head is gated so the outputs read zero whenever the queue is empty.
    assign head         = mem[rd_ptr_reg];
    assign out_y        = out_valid ? head.y : 32'd0;
    assign out_flags    = out_valid ? head.flags : '0;
    assign sticky_flags = sticky_reg;
    assign count        = count_reg;

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr_reg] <= in_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            sticky_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
            if (clr_sticky) begin
                sticky_reg <= push ? in_entry.flags : '0;
            end else if (push) begin
                sticky_reg <= sticky_reg | in_entry.flags;
            end
        end
    end

endmodule

// File: tb/tb_fp_result_queue.sv
module tb_fp_result_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a, in_b, in_y;
    logic        in_op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_y;
    logic [4:0]  out_flags;
    logic [4:0]  sticky_flags;
    logic        clr_sticky;
    logic [2:0]  count;

    fp_result_queue #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_op        (in_op),
        .in_y         (in_y),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_y        (out_y),
        .out_flags    (out_flags),
        .sticky_flags (sticky_flags),
        .clr_sticky   (clr_sticky),
        .count        (count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit verbose = 1'b1;

    // Reference state: queue of {flags, y} and sticky flags.
    logic [36:0] mq[$];
    logic [4:0]  msticky;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference fix-up, evaluated rule by rule from the IEEE field values.
    function automatic logic [36:0] ref_fix(input logic [31:0] a, input logic [31:0] b,
                                            input logic op, input logic [31:0] y);
        int  ea, eb, ey, ma, mb;
        bit  sa, sb, sy, sub;
        ea = int'(a[30:23]); eb = int'(b[30:23]); ey = int'(y[30:23]);
        ma = int'(a[22:0]);  mb = int'(b[22:0]);
        sa = a[31]; sb = b[31] ^ op; sy = y[31];
        sub = (sa != sb);
        if ((ea == 255 && ma != 0) || (eb == 255 && mb != 0))
            return {5'b10000, 32'h7FC00000};
        if (ea == 255 && eb == 255) begin
            if (sub) return {5'b10000, 32'h7FC00000};
            return {5'b00001, sa, 31'h7F800000};
        end
        if (ea == 255) return {5'b00001, sa, 31'h7F800000};
        if (eb == 255) return {5'b00001, sb, 31'h7F800000};
        if (ea == 0 && eb == 0) return {5'b00010, (sa && sb), 31'd0};
        if (ea == 0) return {5'b00000, sb, b[30:0]};
        if (eb == 0) return {5'b00000, a};
        if (sub && ea == eb && ma == mb) return {5'b00010, 32'd0};
        if (ey == 255) return {5'b01001, sy, 31'h7F800000};
        if (sub && (ey == 0 || ey > ((ea > eb) ? ea : eb))) return {5'b00110, sy, 31'd0};
        return {5'b00000, y};
    endfunction

    task automatic compare_model();
        int sz;
        sz = mq.size();
        check("count", 64'(count), 64'(sz));
        check("in_ready", 64'(in_ready), 64'(sz < DEPTH));
        check("out_valid", 64'(out_valid), 64'(sz != 0));
        check("sticky", 64'(sticky_flags), 64'(msticky));
        if (sz != 0) begin
            check("out_y", 64'(out_y), 64'(mq[0][31:0]));
            check("out_flags", 64'(out_flags), 64'(mq[0][36:32]));
        end
    endtask

    // One clock: drive, compare against the model, clock, advance the model.
    task automatic cycle(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic op, input logic [31:0] y, input logic ordy,
                         input logic clr, input logic r);
        bit          push, pop;
        logic [36:0] e;
        rst = r; in_valid = v; in_a = a; in_b = b; in_op = op; in_y = y;
        out_ready = ordy; clr_sticky = clr;
        #1;
        compare_model();
        e    = ref_fix(a, b, op, y);
        push = !r && v && (mq.size() < DEPTH);
        pop  = !r && ordy && (mq.size() != 0);
        if (verbose)
            $display("txn rst=%0b push=%0b pop=%0b a=%h b=%h op=%0b y=%h -> %h/%b count=%0d",
                     r, push, pop, a, b, op, y, e[31:0], e[36:32], count);
        @(posedge clk);
        #1;
        if (r) begin
            mq.delete();
            msticky = '0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back(e);
            if (clr) msticky = push ? e[36:32] : 5'd0;
            else if (push) msticky = msticky | e[36:32];
        end
    endtask

    task automatic idle(input logic ordy);
        cycle(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, ordy, 1'b0, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && mq.size() != 0; i++) idle(1'b1);
        check("drain_empty", 64'(out_valid), 64'(0));
    endtask

    function automatic logic [31:0] pick_operand();
        logic s;
        s = 1'($urandom);
        case ($urandom_range(0, 9))
            0:       return {s, 31'd0};
            1:       return {s, 8'h00, 23'($urandom)};
            2:       return {s, 8'hFF, 23'd0};
            3:       return {s, 8'hFF, 22'($urandom), 1'b1};
            4:       return {s, 8'hFE, 23'($urandom)};
            default: return {s, 8'($urandom_range(1, 254)), 23'($urandom)};
        endcase
    endfunction

    function automatic logic [31:0] pick_result();
        logic s;
        s = 1'($urandom);
        case ($urandom_range(0, 5))
            0:       return {s, 8'hFF, 23'($urandom)};
            1:       return {s, 8'h00, 23'($urandom)};
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL timeout count=%0d expected completion", count);
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a, b;
        msticky = '0;
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = 1'b0; in_y = '0;
        out_ready = 1'b0; clr_sticky = 1'b0;
        @(posedge clk); #1;

        // Reset state
        cycle(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        check("rst_count", 64'(count), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_sticky", 64'(sticky_flags), 64'(0));
        check("rst_out_y", 64'(out_y), 64'(0));
        check("rst_out_flags", 64'(out_flags), 64'(0));

        // 1.0 + 2.0 pass-through, latency one
        cycle(1'b1, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 1'b1, 1'b0, 1'b0);
        check("pass_valid", 64'(out_valid), 64'(1));
        check("pass_y", 64'(out_y), 64'(32'h40400000));
        check("pass_flags", 64'(out_flags), 64'(0));
        drain();

        // inf - inf -> invalid
        cycle(1'b1, 32'h7F800000, 32'h7F800000, 1'b1, 32'h12345678, 1'b0, 1'b0, 1'b0);
        check("infsub_y", 64'(out_y), 64'(32'h7FC00000));
        check("infsub_flags", 64'(out_flags), 64'(5'b10000));
        check("infsub_sticky4", 64'(sticky_flags[4]), 64'(1));
        drain();

        // exact cancellation
        cycle(1'b1, 32'h3F800000, 32'h3F800000, 1'b1, $urandom, 1'b0, 1'b0, 1'b0);
        check("cancel_y", 64'(out_y), 64'(32'h00000000));
        check("cancel_flags", 64'(out_flags), 64'(5'b00010));
        drain();

        // overflow
        cycle(1'b1, 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b0, 1'b0, 1'b0);
        check("ovf_y", 64'(out_y), 64'(32'h7F800000));
        check("ovf_flags", 64'(out_flags), 64'(5'b01001));
        drain();

        // sticky clear alone, then clear with a same-cycle NaN push
        cycle(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
        check("clr_sticky", 64'(sticky_flags), 64'(0));
        cycle(1'b1, 32'h7FC00001, 32'h3F800000, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        check("clr_push_sticky", 64'(sticky_flags), 64'(5'b10000));
        drain();

        // Fill with out_ready low: fifth entry is held off
        for (int i = 0; i < 4; i++)
            cycle(1'b1, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000 + 32'(i), 1'b0, 1'b0, 1'b0);
        check("full_count", 64'(count), 64'(4));
        check("full_in_ready", 64'(in_ready), 64'(0));
        cycle(1'b1, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400099, 1'b1, 1'b0, 1'b0);
        check("full_no_push_count", 64'(count), 64'(3));
        for (int i = 1; i < 4; i++) begin
            check("order_y", 64'(out_y), 64'(32'h40400000 + 32'(i)));
            idle(1'b1);
        end
        check("drained_count", 64'(count), 64'(0));

        // Reset mid-operation with a push asserted
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h7F800000, 32'h7F800000, 1'b1, 32'd0, 1'b0, 1'b0, 1'b1);
        check("midrst_count", 64'(count), 64'(0));
        check("midrst_out_valid", 64'(out_valid), 64'(0));
        check("midrst_sticky", 64'(sticky_flags), 64'(0));

        // Randomized traffic against the reference model
        verbose = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            a = pick_operand();
            b = ($urandom_range(0, 9) == 0) ? {1'($urandom), a[30:0]} : pick_operand();
            cycle(($urandom_range(0, 9) < 6), a, b, 1'($urandom), pick_result(),
                  ($urandom_range(0, 9) < 6), ($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 199) == 0));
        end
        idle(1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
